ltssm_detect_poll_ctrl: RTL and testbench

Detect/Polling substate controller for the LTSSM. It drives the shared link timer (start pulse, timeout code, 1 ms secondary enable) and sequences Detect.Quiet → Detect.Active → Polling.Active → Polling.Configuration → Configuration entry. Transitions are taken on timer timeouts, receiver-detect results and TS1/TS2 exchange counts. It sits between the PHY/ordered-set logic and the timer.

---
 rtl/ltssm_pkg.sv | 31 +++
 rtl/ts_sat_counter.sv | 31 +++
 rtl/ltssm_detect_poll_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ltssm_detect_poll_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ltssm_pkg.sv
// Shared LTSSM types: state encoding, link-timer time codes and default TS thresholds.
package ltssm_pkg;

  typedef enum logic [2:0] {
    DETECT_QUIET  = 3'd0,
    DETECT_ACTIVE = 3'd1,
    POLL_ACTIVE   = 3'd2,
    POLL_CONFIG   = 3'd3,
    CONFIG_ENTRY  = 3'd4
  } ltssm_state_e;

  localparam int T12 = 0;
  localparam int T24 = 1;
  localparam int T2  = 2;
  localparam int T48 = 3;

  localparam int DEF_TX_TS1_MIN = 1024;
  localparam int DEF_RX_TS_MIN  = 8;
  localparam int DEF_TX_TS2_MIN = 16;

  // Timeout code the shared link timer runs while in a given state.
  function automatic int time_code(ltssm_state_e s);
    case (s)
      DETECT_ACTIVE: return T2;
      POLL_ACTIVE:   return T24;
      POLL_CONFIG:   return T48;
      default:       return T12;
    endcase
  endfunction

endpackage

// File: rtl/ts_sat_counter.sv
// Saturating ordered-set counter; 'reached' already includes this cycle's increment.
module ts_sat_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] threshold,
  output logic         reached
);

  logic [W-1:0] cnt;
  logic [W:0]   base;
  logic [W:0]   sum;

  // 'clear' treats the stored count as zero this cycle so an event in the
  // same cycle is still counted (state-entry events count toward the exit).
  always_comb begin
    base    = clear ? '0 : {1'b0, cnt};
    sum     = base + (W+1)'(inc);
    reached = (sum >= {1'b0, threshold});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         cnt <= '0;
    else if (reached) cnt <= threshold;
    else              cnt <= sum[W-1:0];
  end

endmodule

// File: rtl/ltssm_detect_poll_ctrl.sv
// LTSSM Detect/Polling substate controller driving the shared link timer.
// Optional LTSSM_QUIET_MIN_EN enforces a 1 ms minimum Detect.Quiet before electrical-idle exit.
module ltssm_detect_poll_ctrl
  import ltssm_pkg::*;
#(
  parameter int TIME_VALUE_WIDTH = 3,
  parameter int TX_TS1_MIN       = DEF_TX_TS1_MIN,
  parameter int RX_TS_MIN        = DEF_RX_TS_MIN,
  parameter int TX_TS2_MIN       = DEF_TX_TS2_MIN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        timeout1,
  input  logic                        timeout2,
  input  logic                        rx_elec_idle_exit,
  input  logic                        rcvr_det_done,
  input  logic                        rcvr_detected,
  input  logic                        rx_ts1_valid,
  input  logic                        rx_ts2_valid,
  input  logic                        tx_os_done,
  input  logic                        link_down,
  output logic                        timer_start,
  output logic [TIME_VALUE_WIDTH-1:0] timer_value1,
  output logic                        timer_value2,
  output logic                        rx_det_req,
  output logic                        tx_send_ts1,
  output logic                        tx_send_ts2,
  output logic                        detect_fail,
  output logic                        cfg_entry,
  output logic [2:0]                  state
);

  localparam int TX_MAX  = (TX_TS1_MIN > TX_TS2_MIN) ? TX_TS1_MIN : TX_TS2_MIN;
  localparam int CNT_MAX = (TX_MAX > RX_TS_MIN) ? TX_MAX : RX_TS_MIN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ltssm_state_e state_q;
  ltssm_state_e state_nxt;
  logic         entry_q;
  logic         ts2_seen_q;
  logic         fail_nxt;
  logic         to1;
  logic         eidle_ok;
  logic         tv2_nxt;
  logic         changing;

  logic             rx_inc, rx_clear, rx_reached;
  logic             tx_inc, tx_clear, tx_reached;
  logic [CNT_W-1:0] rx_thr, tx_thr;

  // The timer still shows the previous count during its restart cycle.
  assign to1      = timeout1 & ~timer_start;
  assign changing = (state_nxt != state_q);

`ifdef LTSSM_QUIET_MIN_EN
  logic to2;
  logic to2_seen_q;

  assign to2      = timeout2 & ~timer_start;
  assign eidle_ok = rx_elec_idle_exit & (to2_seen_q | to2);
  assign tv2_nxt  = (state_nxt == DETECT_QUIET);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          to2_seen_q <= 1'b0;
    else if (changing) to2_seen_q <= 1'b0;
    else if (to2)      to2_seen_q <= 1'b1;
  end
`else
  logic unused_timeout2;

  assign unused_timeout2 = timeout2;
  assign eidle_ok        = rx_elec_idle_exit;
  assign tv2_nxt         = 1'b0;
`endif

  assign rx_inc   = ((state_q == POLL_ACTIVE) & (rx_ts1_valid | rx_ts2_valid)) |
                    ((state_q == POLL_CONFIG) & rx_ts2_valid);
  assign rx_clear = entry_q | ((state_q == POLL_CONFIG) & rx_ts1_valid & ~rx_ts2_valid);
  assign rx_thr   = CNT_W'(RX_TS_MIN);

  assign tx_inc   = tx_os_done & ((state_q == POLL_ACTIVE) |
                                  ((state_q == POLL_CONFIG) & ts2_seen_q));
  assign tx_clear = entry_q;
  assign tx_thr   = (state_q == POLL_CONFIG) ? CNT_W'(TX_TS2_MIN) : CNT_W'(TX_TS1_MIN);

  ts_sat_counter #(.W(CNT_W)) u_rx_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (rx_clear),
    .inc       (rx_inc),
    .threshold (rx_thr),
    .reached   (rx_reached)
  );

  ts_sat_counter #(.W(CNT_W)) u_tx_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (tx_clear),
    .inc       (tx_inc),
    .threshold (tx_thr),
    .reached   (tx_reached)
  );

  always_comb begin
    state_nxt = state_q;
    fail_nxt  = 1'b0;
    if (link_down && (state_q != DETECT_QUIET)) begin
      state_nxt = DETECT_QUIET;
    end else begin
      case (state_q)
        DETECT_QUIET: begin
          if (to1 || eidle_ok) state_nxt = DETECT_ACTIVE;
        end
        DETECT_ACTIVE: begin
          if (rcvr_det_done) begin
            state_nxt = rcvr_detected ? POLL_ACTIVE : DETECT_QUIET;
            fail_nxt  = ~rcvr_detected;
          end else if (to1) begin
            state_nxt = DETECT_QUIET;
          end
        end
        POLL_ACTIVE: begin
          if (tx_reached && rx_reached) state_nxt = POLL_CONFIG;
          else if (to1)                 state_nxt = DETECT_QUIET;
        end
        POLL_CONFIG: begin
          if (tx_reached && rx_reached) state_nxt = CONFIG_ENTRY;
          else if (to1)                 state_nxt = DETECT_QUIET;
        end
        default: state_nxt = state_q;
      endcase
    end
  end

  // TS2 transmit counting in Polling.Configuration starts once a TS2 has arrived.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                           ts2_seen_q <= 1'b0;
    else if (changing)                                  ts2_seen_q <= 1'b0;
    else if ((state_q == POLL_CONFIG) && rx_ts2_valid)  ts2_seen_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= DETECT_QUIET;
      entry_q      <= 1'b1;
      timer_start  <= 1'b1;
      timer_value1 <= '0;
      timer_value2 <= 1'b0;
      rx_det_req   <= 1'b0;
      tx_send_ts1  <= 1'b0;
      tx_send_ts2  <= 1'b0;
      detect_fail  <= 1'b0;
      cfg_entry    <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      entry_q      <= changing;
      timer_start  <= changing && (state_nxt != CONFIG_ENTRY);
      timer_value1 <= TIME_VALUE_WIDTH'(time_code(state_nxt));
      timer_value2 <= tv2_nxt;
      rx_det_req   <= changing && (state_nxt == DETECT_ACTIVE);
      tx_send_ts1  <= (state_nxt == POLL_ACTIVE);
      tx_send_ts2  <= (state_nxt == POLL_CONFIG);
      detect_fail  <= fail_nxt;
      cfg_entry    <= (state_nxt == CONFIG_ENTRY);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ltssm_detect_poll_ctrl.sv
// Scoreboard bench for ltssm_detect_poll_ctrl; honours LTSSM_QUIET_MIN_EN when defined.
module tb_ltssm_detect_poll_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       timeout1, timeout2, rx_elec_idle_exit, rcvr_det_done, rcvr_detected;
  logic       rx_ts1_valid, rx_ts2_valid, tx_os_done, link_down;
  logic       timer_start, timer_value2, rx_det_req, tx_send_ts1, tx_send_ts2;
  logic       detect_fail, cfg_entry;
  logic [2:0] timer_value1;
  logic [2:0] state;

  ltssm_detect_poll_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .timeout1          (timeout1),
    .timeout2          (timeout2),
    .rx_elec_idle_exit (rx_elec_idle_exit),
    .rcvr_det_done     (rcvr_det_done),
    .rcvr_detected     (rcvr_detected),
    .rx_ts1_valid      (rx_ts1_valid),
    .rx_ts2_valid      (rx_ts2_valid),
    .tx_os_done        (tx_os_done),
    .link_down         (link_down),
    .timer_start       (timer_start),
    .timer_value1      (timer_value1),
    .timer_value2      (timer_value2),
    .rx_det_req        (rx_det_req),
    .tx_send_ts1       (tx_send_ts1),
    .tx_send_ts2       (tx_send_ts2),
    .detect_fail       (detect_fail),
    .cfg_entry         (cfg_entry),
    .state             (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    string       name;
    logic [12:0] v;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_err    = 0;

  wire [12:0] act = {state, timer_start, timer_value1, timer_value2, rx_det_req,
                     tx_send_ts1, tx_send_ts2, detect_fail, cfg_entry};

  // Expected output vector for a state, from the state/time-code table.
  function automatic logic [12:0] exp_vec(int st, bit ts, bit rdr, bit df);
    logic [2:0] code;
    logic       tv2;
    case (st)
      1:       code = 3'd2;
      2:       code = 3'd1;
      3:       code = 3'd3;
      default: code = 3'd0;
    endcase
    tv2 = 1'b0;
`ifdef LTSSM_QUIET_MIN_EN
    tv2 = (st == 0);
`endif
    return {3'(st), ts, code, tv2, rdr, (st == 2), (st == 3), df, (st == 4)};
  endfunction

  task automatic chk(string name, int dly, logic [12:0] v);
    exp_t e;
    e.cyc  = cyc + dly;
    e.name = name;
    e.v    = v;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      n_checks++;
      if (act !== e.v || e.cyc != cyc) begin
        n_err++;
        $display("FAIL %s: cycle %0d got %b, expected %b (for cycle %0d)",
                 e.name, cyc, act, e.v, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    timeout1 = 0; timeout2 = 0; rx_elec_idle_exit = 0; rcvr_det_done = 0;
    rcvr_detected = 0; rx_ts1_valid = 0; rx_ts2_valid = 0; tx_os_done = 0;
    link_down = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 200000", $time);
    $fatal(1);
  end

  initial begin
    logic [12:0] rv;
    rv    = exp_vec(0, 1, 0, 0);
    rv[5] = 1'b0;
    clr_in();
    rst = 0;
    tick(); tick();
    chk("reset_hold", 0, rv);
    tick(); rst = 1;
    chk("release_first", 0, rv);
    tick();
    chk("quiet_idle", 0, exp_vec(0, 0, 0, 0));
    tick(); timeout1 = 1;
    chk("to_detect_active", 1, exp_vec(1, 1, 1, 0));
    tick();
    chk("stale_timeout", 1, exp_vec(1, 0, 0, 0));
    tick(); timeout1 = 0; rcvr_det_done = 1; rcvr_detected = 0;
    chk("detect_fail", 1, exp_vec(0, 1, 0, 1));
    tick(); clr_in();
    chk("fail_pulse_end", 1, exp_vec(0, 0, 0, 0));
    tick(); timeout1 = 1;
    tick(); clr_in();
    tick(); rcvr_det_done = 1; rcvr_detected = 1; timeout1 = 1;
    chk("detect_beats_timeout", 1, exp_vec(2, 1, 0, 0));
    tick(); clr_in();

    // Polling.Active one TS1 short, then timeout
    for (int i = 0; i < 1023; i++) begin
      tx_os_done   = 1;
      rx_ts1_valid = (i < 8);
      tick();
    end
    clr_in();
    chk("tx1023_hold", 0, exp_vec(2, 0, 0, 0));
    timeout1 = 1;
    chk("poll_active_timeout", 1, exp_vec(0, 1, 0, 0));
    tick(); clr_in();
    tick(); timeout1 = 1;
    tick(); clr_in(); rcvr_det_done = 1; rcvr_detected = 1;
    chk("redetect", 1, exp_vec(2, 1, 0, 0));
    tick(); clr_in();

    // Polling.Active full exit; last rx and tx land in the exit cycle
    for (int i = 0; i < 1024; i++) begin
      tx_os_done   = 1;
      rx_ts1_valid = (i >= 1016);
      rx_ts2_valid = (i >= 1020);
      if (i == 1022) chk("pa_not_yet", 1, exp_vec(2, 0, 0, 0));
      if (i == 1023) chk("pa_exit", 1, exp_vec(3, 1, 0, 0));
      tick();
    end
    clr_in();

    // Polling.Configuration: 5 TS2, TS1 restart, then 8 TS2 (first with TS1 too)
    for (int j = 0; j < 25; j++) begin
      rx_ts2_valid = (j < 5) || (j >= 17);
      rx_ts1_valid = (j == 5) || (j == 17);
      tx_os_done   = (j >= 1) && (j <= 16);
      if (j == 23) chk("pc_not_yet", 1, exp_vec(3, 0, 0, 0));
      if (j == 24) chk("cfg_entry", 1, exp_vec(4, 0, 0, 0));
      tick();
    end
    clr_in();
    timeout1 = 1;
    chk("cfg_hold_timeout", 1, exp_vec(4, 0, 0, 0));
    tick(); timeout1 = 0; link_down = 1;
    chk("link_down", 1, exp_vec(0, 1, 0, 0));
    tick();
    chk("link_down_in_quiet", 1, exp_vec(0, 0, 0, 0));
    tick(); clr_in();

`ifdef LTSSM_QUIET_MIN_EN
    rx_elec_idle_exit = 1;
    chk("eidle_blocked", 1, exp_vec(0, 0, 0, 0));
    tick(); timeout2 = 1;
    chk("eidle_after_to2", 1, exp_vec(1, 1, 1, 0));
    tick(); clr_in();
`else
    rx_elec_idle_exit = 1;
    chk("eidle_exit", 1, exp_vec(1, 1, 1, 0));
    tick(); clr_in();
`endif
    tick(); timeout1 = 1;
    chk("da_timeout_no_fail", 1, exp_vec(0, 1, 0, 0));
    tick(); clr_in();

    // Asynchronous reset mid Polling.Active
    tick(); timeout1 = 1;
    tick(); clr_in(); rcvr_det_done = 1; rcvr_detected = 1;
    tick(); clr_in();
    for (int i = 0; i < 1000; i++) begin
      tx_os_done   = 1;
      rx_ts1_valid = (i < 8);
      tick();
    end
    clr_in();
    chk("pre_reset", 0, exp_vec(2, 0, 0, 0));
    tick(); rst = 0;
    chk("mid_reset", 0, rv);
    tick(); rst = 1;
    chk("reset_release2", 0, rv);
    tick(); timeout1 = 1;
    tick(); clr_in(); rcvr_det_done = 1; rcvr_detected = 1;
    tick(); clr_in();
    for (int i = 0; i < 100; i++) begin
      tx_os_done   = 1;
      rx_ts1_valid = (i < 8);
      tick();
    end
    clr_in();
    chk("after_reset_poll", 0, exp_vec(2, 0, 0, 0));

    for (int k = 0; k < 5 && sbq.size() > 0; k++) tick();
    if (sbq.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
